// File: rtl/serial_sub_str.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// The per-bit datapath is a structural full subtractor feeding a borrow flop.

module half_sub (
   input  logic x_i,
   input  logic y_i,
   output logic d_o,
   output logic bo_o
);
   assign d_o  = x_i ^ y_i;
   assign bo_o = ~x_i & y_i;
endmodule

module full_sub (
   input  logic x_i,
   input  logic y_i,
   input  logic bi_i,
   output logic d_o,
   output logic bo_o
);
   logic d1, b1, b2;

   half_sub u_hs0 (.x_i(x_i), .y_i(y_i),  .d_o(d1),  .bo_o(b1));
   half_sub u_hs1 (.x_i(d1),  .y_i(bi_i), .d_o(d_o), .bo_o(b2));

   assign bo_o = b1 | b2;
endmodule

module serial_sub_str #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             brw_q, brw_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic accept, last, bit_d, bit_bo;

   // DONE accepts a new start just like IDLE, giving back-to-back operation.
   assign accept = start_i && (state_q != RUN);
   assign last   = (cnt_q == CW'(WIDTH - 1));

   full_sub u_fs (
      .x_i (a_sr_q[0]),
      .y_i (b_sr_q[0]),
      .bi_i(brw_q),
      .d_o (bit_d),
      .bo_o(bit_bo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN:     if (last)    state_d = DONE;
         DONE:    state_d = start_i ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == RUN);
      done_o = (state_q == DONE);
   end

   always_comb begin
      a_sr_d = a_sr_q;
      b_sr_d = b_sr_q;
      diff_d = diff_q;
      brw_d  = brw_q;
      bout_d = bout_q;
      cnt_d  = cnt_q;
      if (accept) begin
         a_sr_d = a_i;
         b_sr_d = b_i;
         brw_d  = bin_i;
         cnt_d  = '0;
      end else if (state_q == RUN) begin
         a_sr_d = a_sr_q >> 1;
         b_sr_d = b_sr_q >> 1;
         // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
         diff_d = {bit_d, diff_q[WIDTH-1:1]};
         brw_d  = bit_bo;
         cnt_d  = cnt_q + CW'(1);
         if (last) bout_d = bit_bo;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_q <= '0;
         b_sr_q <= '0;
         diff_q <= '0;
         brw_q  <= 1'b0;
         bout_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         a_sr_q <= a_sr_d;
         b_sr_q <= b_sr_d;
         diff_q <= diff_d;
         brw_q  <= brw_d;
         bout_q <= bout_d;
         cnt_q  <= cnt_d;
      end
   end

   assign diff_o = diff_q;
   assign bout_o = bout_q;
endmodule

// File: tb/tb_serial_sub_str.sv
// Randomized self-checking bench for serial_sub_str against an arithmetic
// reference model (plain integer subtraction and unsigned comparison).

module tb_serial_sub_str;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         bin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, bout;
   logic [W-1:0] diff;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] r_diff;
   logic         r_bout;
   int           r_lat, r_busy;

   serial_sub_str #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(start),
      .a_i    (a),
      .b_i    (b),
      .bin_i  (bin),
      .busy_o (busy),
      .done_o (done),
      .diff_o (diff),
      .bout_o (bout)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] m_diff(input int ia, input int ib, input int ibin);
      int t;
      t = (ia - ib - ibin) & ((1 << W) - 1);
      return W'(t);
   endfunction

   function automatic logic m_bout(input int ia, input int ib, input int ibin);
      return (ia < ib + ibin);
   endfunction

   // Issues one start at the current negedge; returns at the negedge where done is seen.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      start = 1'b1; a = ta; b = tb; bin = tbin;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      r_lat = -1; r_busy = 0;
      for (int i = 0; i < 4 * W; i++) begin
         if (busy) r_busy++;
         if (done) begin r_lat = i; break; end
         @(negedge clk);
      end
      r_diff = diff; r_bout = bout;
      $display("op a=%h b=%h bin=%0d -> diff=%h bout=%0d lat=%0d busy_cycles=%0d",
               ta, tb, tbin, r_diff, r_bout, r_lat, r_busy);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
      n_cmp++; if (diff !== '0)   begin n_bad++; $display("FAIL reset_diff got=%h want=00", diff); end
      n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL reset_bout got=%b want=0", bout); end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_vectors;
      logic [W-1:0] va[5] = '{8'h5A, 8'h00, 8'h80, 8'h00, 8'hFF};
      logic [W-1:0] vb[5] = '{8'h3C, 8'h01, 8'h7F, 8'h00, 8'hFF};
      logic         vc[5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
      logic [W-1:0] ed[5] = '{8'h1E, 8'hFF, 8'h00, 8'hFF, 8'h00};
      logic         eb[5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         do_op(va[i], vb[i], vc[i]);
         n_cmp++; if (r_diff !== ed[i]) begin n_bad++; $display("FAIL vec%0d_diff got=%h want=%h", i, r_diff, ed[i]); end
         n_cmp++; if (r_bout !== eb[i]) begin n_bad++; $display("FAIL vec%0d_bout got=%b want=%b", i, r_bout, eb[i]); end
         n_cmp++; if (r_lat !== W) begin n_bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, r_lat, W); end
         n_cmp++; if (r_busy !== W) begin n_bad++; $display("FAIL vec%0d_busy_cycles got=%0d want=%0d", i, r_busy, W); end
         @(negedge clk);
         n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL vec%0d_done_pulse got=%b want=0", i, done); end
         n_cmp++; if (diff !== ed[i]) begin n_bad++; $display("FAIL vec%0d_diff_hold got=%h want=%h", i, diff, ed[i]); end
      end
   endtask

   task automatic test_ignore_start;
      int           ndone = 0, li = -1;
      logic [W-1:0] dd = '0;
      logic         bo = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 8'hF0; b = 8'h0F; bin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < W + 6; i++) begin
         if (i == 2) begin start = 1'b1; a = 8'h00; b = W'($urandom); end
         else if (i == 3) start = 1'b0;
         else if (i == 5) b = W'($urandom);
         if (done) begin ndone++; li = i; dd = diff; bo = bout; end
         @(negedge clk);
      end
      $display("op a=f0 b=0f bin=0 (start pulsed mid-run) -> diff=%h bout=%0d dones=%0d", dd, bo, ndone);
      n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL ign_done_count got=%0d want=1", ndone); end
      n_cmp++; if (li !== W) begin n_bad++; $display("FAIL ign_latency got=%0d want=%0d", li, W); end
      n_cmp++; if (dd !== 8'hE1) begin n_bad++; $display("FAIL ign_diff got=%h want=e1", dd); end
      n_cmp++; if (bo !== 1'b0) begin n_bad++; $display("FAIL ign_bout got=%b want=0", bo); end
   endtask

   task automatic test_async_reset;
      int ndone = 0, nbusy = 0;
      logic [W-1:0] ra, rb;
      logic         rc;
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL arst_done got=%b want=0", done); end
      n_cmp++; if (diff !== '0)   begin n_bad++; $display("FAIL arst_diff got=%h want=00", diff); end
      n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL arst_bout got=%b want=0", bout); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W + 4; i++) begin
         if (done) ndone++;
         if (busy) nbusy++;
         @(negedge clk);
      end
      n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL arst_no_done got=%0d want=0", ndone); end
      n_cmp++; if (nbusy !== 0) begin n_bad++; $display("FAIL arst_no_busy got=%0d want=0", nbusy); end
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rc);
      n_cmp++; if (r_diff !== m_diff(ra, rb, rc)) begin n_bad++; $display("FAIL arst_fresh_diff got=%h want=%h", r_diff, m_diff(ra, rb, rc)); end
      n_cmp++; if (r_bout !== m_bout(ra, rb, rc)) begin n_bad++; $display("FAIL arst_fresh_bout got=%b want=%b", r_bout, m_bout(ra, rb, rc)); end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      @(negedge clk);
      do_op(ra, rb, rc);
      n_cmp++; if (r_diff !== m_diff(ra, rb, rc)) begin n_bad++; $display("FAIL b2b_first_diff got=%h want=%h", r_diff, m_diff(ra, rb, rc)); end
      do_op(8'h10, 8'h20, 1'b0);
      n_cmp++; if (r_lat !== W) begin n_bad++; $display("FAIL b2b_latency got=%0d want=%0d", r_lat, W); end
      n_cmp++; if (r_busy !== W) begin n_bad++; $display("FAIL b2b_busy_cycles got=%0d want=%0d", r_busy, W); end
      n_cmp++; if (r_diff !== 8'hF0) begin n_bad++; $display("FAIL b2b_diff got=%h want=f0", r_diff); end
      n_cmp++; if (r_bout !== 1'b1) begin n_bad++; $display("FAIL b2b_bout got=%b want=1", r_bout); end
   endtask

   task automatic test_random;
      logic [W-1:0] ra, rb;
      logic         rc;
      @(negedge clk);
      for (int n = 0; n < 30; n++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         if (n % 5 == 0) rb = ra;
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         do_op(ra, rb, rc);
         n_cmp++; if (r_diff !== m_diff(ra, rb, rc)) begin n_bad++; $display("FAIL rnd%0d_diff got=%h want=%h", n, r_diff, m_diff(ra, rb, rc)); end
         n_cmp++; if (r_bout !== m_bout(ra, rb, rc)) begin n_bad++; $display("FAIL rnd%0d_bout got=%b want=%b", n, r_bout, m_bout(ra, rb, rc)); end
         n_cmp++; if (r_lat !== W) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, r_lat, W); end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_start();
      test_async_reset();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
